// File: rtl/run_ctrl.sv
// run_ctrl: start/stop sequencer for a small processor core.
//
// A host raises req to start a run. The core is held in reset for
// HOLD_CYC cycles, then released. The run ends on core_done (DONE), on
// reaching MAX_CYC RUN cycles (ERR), or on req dropping early (abort, back
// to IDLE). DONE/ERR are held until the host drops req.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : synchronous, active-high reset
//   req        : host start request (4-phase level handshake)
//   core_done  : core finished its program
//   core_reset : core reset, high = core held (low only in RUN)
//   busy       : high in HOLD or RUN
//   done       : high in DONE
//   err        : high in ERR (timeout)
//   cycles     : RUN cycles counted in the current or last run
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for req; core held; cycles shows the last run
// HOLD  | req accepted; core held for HOLD_CYC cycles
// RUN   | core released; cycles counts up each cycle
// DONE  | core signalled done; held until req drops
// ERR   | MAX_CYC RUN cycles without done; held until req drops

module run_ctrl #(
  parameter int HOLD_CYC = 2,
  parameter int CW       = 16,
  parameter int MAX_CYC  = 1000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          core_done,
  output logic          core_reset,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] cycles
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HOLD = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  // Hold timer counts down to zero; loading HOLD_CYC-1 gives exactly
  // HOLD_CYC cycles in HOLD because the zero cycle is also spent there.
  localparam logic [3:0]    HOLD_LOAD = 4'(HOLD_CYC - 1);
  // Timeout fires on the edge that would make cycles equal MAX_CYC.
  localparam logic [CW-1:0] LAST_RUN  = CW'(MAX_CYC - 1);

  logic [2:0] state;
  logic [3:0] hold_cnt;

  // Outputs decode registered state only: no input-to-output paths.
  assign core_reset = (state != S_RUN);
  assign busy       = (state == S_HOLD) || (state == S_RUN);
  assign done       = (state == S_DONE);
  assign err        = (state == S_ERR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cycles   <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            state    <= S_HOLD;
            cycles   <= '0;
            hold_cnt <= HOLD_LOAD;
          end
        end
        S_HOLD: begin
          if (!req) begin
            state <= S_IDLE;
          end else if (hold_cnt == 4'd0) begin
            state <= S_RUN;
          end else begin
            hold_cnt <= hold_cnt - 4'd1;
          end
        end
        S_RUN: begin
          // Abort leaves cycles untouched; otherwise this cycle is counted
          // whether the run continues or ends. Done wins a tie with timeout.
          if (!req) begin
            state <= S_IDLE;
          end else begin
            cycles <= cycles + CW'(1);
            if (core_done) begin
              state <= S_DONE;
            end else if (cycles == LAST_RUN) begin
              state <= S_ERR;
            end
          end
        end
        S_DONE, S_ERR: begin
          if (!req) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed test of run_ctrl with a cycle-tagged scoreboard.
// The stimulus process pushes hand-computed expected outputs tagged with
// the current cycle number; a monitor on the falling edge pops and compares.

module tb_run_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        core_done;
  logic        core_reset;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] cycles;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  typedef struct {
    int          cyc;
    logic [95:0] name;
    logic        cr;
    logic        bz;
    logic        dn;
    logic        er;
    logic [15:0] cy;
  } exp_t;

  exp_t sb[$];

  run_ctrl #(.HOLD_CYC(2), .CW(16), .MAX_CYC(1000)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .core_done  (core_done),
    .core_reset (core_reset),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cycles     (cycles)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic [95:0] nm, input logic cr, input logic bz,
                            input logic dn, input logic er, input int cy);
    exp_t e;
    e.cyc  = cyc;
    e.name = nm;
    e.cr   = cr;
    e.bz   = bz;
    e.dn   = dn;
    e.er   = er;
    e.cy   = 16'(cy);
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      if (e.cyc != cyc || core_reset !== e.cr || busy !== e.bz ||
          done !== e.dn || err !== e.er || cycles !== e.cy) begin
        miscompares++;
        $display("FAIL %0s cyc=%0d/%0d got core_reset=%b busy=%b done=%b err=%b cycles=%0d want core_reset=%b busy=%b done=%b err=%b cycles=%0d",
                 e.name, cyc, e.cyc, core_reset, busy, done, err, cycles,
                 e.cr, e.bz, e.dn, e.er, e.cy);
      end
    end
  end

  initial begin
    reset     = 1'b1;
    req       = 1'b0;
    core_done = 1'b0;
    step(2);
    expect_out("rst", 1, 0, 0, 0, 0);

    // Normal run: done on RUN cycle 37.
    reset = 1'b0;
    req   = 1'b1;
    step(1); expect_out("hold1", 1, 1, 0, 0, 0);
    step(1); expect_out("hold2", 1, 1, 0, 0, 0);
    step(1); expect_out("run0", 0, 1, 0, 0, 0);
    step(36); expect_out("run36", 0, 1, 0, 0, 36);
    core_done = 1'b1;
    step(1); expect_out("done37", 1, 0, 1, 0, 37);
    core_done = 1'b0;
    // Handshake hold: 50 cycles with req high, no restart.
    for (int i = 0; i < 50; i++) begin
      step(1); expect_out("done_hold", 1, 0, 1, 0, 37);
    end
    req = 1'b0;
    step(1); expect_out("idle1", 1, 0, 0, 0, 37);
    req = 1'b1;
    step(1); expect_out("fresh_hold", 1, 1, 0, 0, 0);
    step(2); expect_out("fresh_run0", 0, 1, 0, 0, 0);
    core_done = 1'b1;
    step(1); expect_out("done1", 1, 0, 1, 0, 1);
    core_done = 1'b0;
    req = 1'b0;
    step(1); expect_out("idle2", 1, 0, 0, 0, 1);

    // Timeout.
    req = 1'b1;
    step(3); expect_out("to_run0", 0, 1, 0, 0, 0);
    step(999); expect_out("to_run999", 0, 1, 0, 0, 999);
    step(1); expect_out("timeout", 1, 0, 0, 1, 1000);
    step(3); expect_out("err_hold", 1, 0, 0, 1, 1000);
    core_done = 1'b1;
    step(1); expect_out("err_cdone", 1, 0, 0, 1, 1000);
    core_done = 1'b0;
    req = 1'b0;
    step(1); expect_out("idle_err", 1, 0, 0, 0, 1000);

    // Done on the timeout cycle wins.
    req = 1'b1;
    step(3); expect_out("tie_run0", 0, 1, 0, 0, 0);
    step(999); expect_out("tie_run999", 0, 1, 0, 0, 999);
    core_done = 1'b1;
    step(1); expect_out("tie_done", 1, 0, 1, 0, 1000);
    core_done = 1'b0;
    req = 1'b0;
    step(1); expect_out("idle_tie", 1, 0, 0, 0, 1000);

    // Abort in RUN, then core_done ignored in IDLE.
    req = 1'b1;
    step(3); expect_out("ab_run0", 0, 1, 0, 0, 0);
    step(10); expect_out("ab_run10", 0, 1, 0, 0, 10);
    req = 1'b0;
    step(1); expect_out("abort_run", 1, 0, 0, 0, 10);
    core_done = 1'b1;
    step(2); expect_out("idle_cdone", 1, 0, 0, 0, 10);
    core_done = 1'b0;

    // Abort in HOLD.
    req = 1'b1;
    step(1); expect_out("ah_hold", 1, 1, 0, 0, 0);
    req = 1'b0;
    step(1); expect_out("abort_hold", 1, 0, 0, 0, 0);

    // Reset mid-run.
    req = 1'b1;
    step(3); expect_out("rr_run0", 0, 1, 0, 0, 0);
    step(5); expect_out("rr_run5", 0, 1, 0, 0, 5);
    reset = 1'b1;
    step(1); expect_out("rst_mid", 1, 0, 0, 0, 0);
    req       = 1'b0;
    reset     = 1'b0;
    core_done = 1'b1;
    step(2); expect_out("rst_cdone", 1, 0, 0, 0, 0);
    core_done = 1'b0;

    // Reset released with req already high: run starts on the first edge.
    reset = 1'b1;
    req   = 1'b1;
    step(1); expect_out("rst_req", 1, 0, 0, 0, 0);
    reset = 1'b0;
    step(1); expect_out("post_hold1", 1, 1, 0, 0, 0);
    step(1); expect_out("post_hold2", 1, 1, 0, 0, 0);
    step(1); expect_out("post_run0", 0, 1, 0, 0, 0);
    step(1); expect_out("post_run1", 0, 1, 0, 0, 1);
    req = 1'b0;
    step(1); expect_out("post_idle", 1, 0, 0, 0, 1);

    step(2);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain got %0d pending entries want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
